// File: rtl/pe_elastic_pkg.sv
// Shared constants and helpers for the elastic PE tile pass-through.
package pe_elastic_pkg;

    localparam int unsigned CH_EAST  = 0;
    localparam int unsigned CH_WEST  = 1;
    localparam int unsigned CH_NORTH = 2;
    localparam int unsigned CH_SOUTH = 3;

    // Pointer width for a DEPTH-entry buffer; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pe_chan_fifo.sv
// One channel of the tile pass-through: DEPTH-entry elastic buffer with
// valid/ready handshakes, global freeze, flush and a popped-flit counter.
module pe_chan_fifo
    import pe_elastic_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 130,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ap_start,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  empty,
    output logic [CNT_WIDTH-1:0]  flit_cnt
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [OCC_W-1:0]      occ;
    logic                  full;
    logic                  push;
    logic                  pop;

    // Ready looks only at registered occupancy, never at out_ready.
    assign full      = (occ == OCC_W'(DEPTH));
    assign empty     = (occ == '0);
    assign in_ready  = ~reset & ap_start & ~full & ~flush;
    assign out_valid = ap_start & ~empty;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready & ~flush;
    assign out_data  = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Counter survives flush; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)    flit_cnt <= '0;
        else if (pop) flit_cnt <= flit_cnt + CNT_WIDTH'(1);
    end

endmodule

// File: rtl/pe_elastic_passthru.sv
// Parametrised pass-through across an empty PE tile: NUM_CH independent
// elastic channels plus an all-empty drain indication.
module pe_elastic_passthru
    import pe_elastic_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DATA_WIDTH = 130,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ap_start,
    input  logic                         flush,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]            in_valid,
    output logic [NUM_CH-1:0]            in_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
    output logic [NUM_CH-1:0]            out_valid,
    input  logic [NUM_CH-1:0]            out_ready,
    output logic                         drained,
    output logic [NUM_CH*CNT_WIDTH-1:0]  flit_cnt
);

    logic [NUM_CH-1:0] empty;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        pe_chan_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .CNT_WIDTH  (CNT_WIDTH)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .ap_start  (ap_start),
            .flush     (flush),
            .in_data   (in_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .in_valid  (in_valid[c]),
            .in_ready  (in_ready[c]),
            .out_data  (out_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .out_valid (out_valid[c]),
            .out_ready (out_ready[c]),
            .empty     (empty[c]),
            .flit_cnt  (flit_cnt[c*CNT_WIDTH +: CNT_WIDTH])
        );
    end

    assign drained = &empty;

endmodule

// File: tb/tb_pe_elastic_passthru.sv
// Scoreboard bench for pe_elastic_passthru: per-channel expected-flit queues
// plus an occupancy model, with a narrow-counter instance for wrap checks.
module tb_pe_elastic_passthru;

    localparam int unsigned NC    = 4;
    localparam int unsigned DW    = 130;
    localparam int unsigned CW    = 16;
    localparam int unsigned DEPTH = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              ap_start;
    logic              flush;
    logic [NC*DW-1:0]  in_data;
    logic [NC-1:0]     in_valid;
    logic [NC-1:0]     in_ready;
    logic [NC*DW-1:0]  out_data;
    logic [NC-1:0]     out_valid;
    logic [NC-1:0]     out_ready;
    logic              drained;
    logic [NC*CW-1:0]  flit_cnt;

    logic              c4_reset;
    logic              c4_ap_start;
    logic              c4_flush;
    logic [7:0]        c4_in_data;
    logic [0:0]        c4_in_valid;
    logic [0:0]        c4_in_ready;
    logic [7:0]        c4_out_data;
    logic [0:0]        c4_out_valid;
    logic [0:0]        c4_out_ready;
    logic              c4_drained;
    logic [3:0]        c4_flit_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] exp_q [NC][$];
    int            occ_m [NC];
    logic [CW-1:0] cnt_m [NC];

    always #5 clk = ~clk;

    pe_elastic_passthru #(.NUM_CH(NC), .DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .ap_start(ap_start), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .drained(drained), .flit_cnt(flit_cnt)
    );

    pe_elastic_passthru #(.NUM_CH(1), .DATA_WIDTH(8), .DEPTH(2), .CNT_WIDTH(4)) dut_c4 (
        .clk(clk), .reset(c4_reset), .ap_start(c4_ap_start), .flush(c4_flush),
        .in_data(c4_in_data), .in_valid(c4_in_valid), .in_ready(c4_in_ready),
        .out_data(c4_out_data), .out_valid(c4_out_valid), .out_ready(c4_out_ready),
        .drained(c4_drained), .flit_cnt(c4_flit_cnt)
    );

    function automatic logic [DW-1:0] out_ch(input int c);
        return out_data[c*DW +: DW];
    endfunction

    function automatic logic [CW-1:0] cnt_ch(input int c);
        return flit_cnt[c*CW +: CW];
    endfunction

    function automatic logic m_in_ready(input int c);
        return ap_start && !flush && !reset && (occ_m[c] < DEPTH);
    endfunction

    function automatic logic m_out_valid(input int c);
        return ap_start && (occ_m[c] > 0);
    endfunction

    task automatic set_in(input int c, input logic [DW-1:0] d, input logic v);
        in_data[c*DW +: DW] = d;
        in_valid[c]         = v;
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            exp_q[c].delete();
            occ_m[c] = 0;
            cnt_m[c] = '0;
        end
    endtask

    // Apply this cycle's handshakes to the model just before the clock edge.
    task automatic model_update();
        for (int c = 0; c < NC; c++) begin
            logic pu, po;
            if (flush) begin
                exp_q[c].delete();
                occ_m[c] = 0;
            end else begin
                po = m_out_valid(c) && out_ready[c];
                pu = m_in_ready(c) && in_valid[c];
                if (po) begin
                    void'(exp_q[c].pop_front());
                    cnt_m[c] = cnt_m[c] + CW'(1);
                end
                if (pu) exp_q[c].push_back(in_data[c*DW +: DW]);
                occ_m[c] = exp_q[c].size();
            end
        end
    endtask

    task automatic next();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        c4_reset  = 1'b1;
        in_valid  = '0;
        out_ready = '0;
        flush     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b0;
        c4_reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; c4_reset = 1'b1;
        ap_start = 1'b1; flush = 1'b0;
        in_data = '1; in_valid = '1; out_ready = '1;
        c4_ap_start = 1'b0; c4_flush = 1'b0; c4_in_data = '0; c4_in_valid = '0; c4_out_ready = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (in_ready !== '0) begin n_err++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready); end
        n_cmp++; if (out_valid !== '0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0000", out_valid); end
        n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data: got %0h expected 0", out_data); end
        n_cmp++; if (drained !== 1'b1) begin n_err++; $display("FAIL reset_drained: got %b expected 1", drained); end
        n_cmp++; if (flit_cnt !== '0) begin n_err++; $display("FAIL reset_flit_cnt: got %0h expected 0", flit_cnt); end
        in_valid = '0; out_ready = '0; in_data = '0; ap_start = 1'b0;
        reset = 1'b0; c4_reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        ap_start = 1'b1;
        set_in(0, DW'(1), 1'b1);
        #1;
        n_cmp++; if (in_ready[0] !== 1'b1) begin n_err++; $display("FAIL basic_ready0: got %b expected 1", in_ready[0]); end
        n_cmp++; if (out_valid[0] !== 1'b0) begin n_err++; $display("FAIL basic_no_bypass: got %b expected 0", out_valid[0]); end
        next();
        set_in(0, DW'(2), 1'b1);
        #1;
        n_cmp++; if (out_valid[0] !== 1'b1) begin n_err++; $display("FAIL basic_valid1: got %b expected 1", out_valid[0]); end
        n_cmp++; if (out_ch(0) !== DW'(1)) begin n_err++; $display("FAIL basic_data1: got %0h expected 1", out_ch(0)); end
        n_cmp++; if (in_ready[0] !== 1'b1) begin n_err++; $display("FAIL basic_ready1: got %b expected 1", in_ready[0]); end
        next();
        set_in(0, '0, 1'b0);
        out_ready[0] = 1'b1;
        #1;
        n_cmp++; if (in_ready[0] !== 1'b0) begin n_err++; $display("FAIL basic_full: got %b expected 0", in_ready[0]); end
        n_cmp++; if (out_ch(0) !== exp_q[0][0]) begin n_err++; $display("FAIL basic_pop1: got %0h expected %0h", out_ch(0), exp_q[0][0]); end
        next();
        #1;
        n_cmp++; if (out_ch(0) !== DW'(2)) begin n_err++; $display("FAIL basic_pop2: got %0h expected 2", out_ch(0)); end
        next();
        out_ready[0] = 1'b0;
        #1;
        n_cmp++; if (cnt_ch(0) !== CW'(2)) begin n_err++; $display("FAIL basic_cnt: got %0d expected 2", cnt_ch(0)); end
        n_cmp++; if (drained !== 1'b1) begin n_err++; $display("FAIL basic_drained: got %b expected 1", drained); end
    endtask

    task automatic test_stream();
        int sent [NC];
        int got  [NC];
        for (int c = 0; c < NC; c++) begin sent[c] = 0; got[c] = 0; end
        ap_start  = 1'b1;
        out_ready = '1;
        for (int cyc = 0; cyc < 110; cyc++) begin
            for (int c = 0; c < NC; c++) set_in(c, DW'(c*256 + sent[c]), sent[c] < 100);
            #1;
            for (int c = 0; c < NC; c++) begin
                n_cmp++;
                if (out_valid[c] !== m_out_valid(c)) begin
                    n_err++; $display("FAIL stream_valid ch%0d cyc%0d: got %b expected %b", c, cyc, out_valid[c], m_out_valid(c));
                end
                n_cmp++;
                if (in_ready[c] !== m_in_ready(c)) begin
                    n_err++; $display("FAIL stream_ready ch%0d cyc%0d: got %b expected %b", c, cyc, in_ready[c], m_in_ready(c));
                end
                if (m_out_valid(c)) begin
                    n_cmp++;
                    if (out_ch(c) !== exp_q[c][0]) begin
                        n_err++; $display("FAIL stream_data ch%0d: got %0h expected %0h", c, out_ch(c), exp_q[c][0]);
                    end
                    got[c]++;
                end
                if (in_valid[c] && m_in_ready(c)) sent[c]++;
            end
            next();
        end
        for (int c = 0; c < NC; c++) begin
            n_cmp++; if (got[c] != 100) begin n_err++; $display("FAIL stream_count ch%0d: got %0d expected 100", c, got[c]); end
            n_cmp++; if (cnt_ch(c) !== cnt_m[c]) begin n_err++; $display("FAIL stream_cnt ch%0d: got %0d expected %0d", c, cnt_ch(c), cnt_m[c]); end
        end
        in_valid = '0; out_ready = '0;
    endtask

    task automatic test_freeze();
        ap_start = 1'b1;
        set_in(2, DW'('hA), 1'b1); #1; next();
        set_in(2, DW'('hB), 1'b1); #1; next();
        set_in(2, '0, 1'b0);
        ap_start = 1'b0; out_ready = '1; in_valid = '1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++; if (out_valid !== '0) begin n_err++; $display("FAIL freeze_valid cyc%0d: got %b expected 0000", i, out_valid); end
            n_cmp++; if (in_ready !== '0) begin n_err++; $display("FAIL freeze_ready cyc%0d: got %b expected 0000", i, in_ready); end
            next();
        end
        ap_start = 1'b1; in_valid = '0;
        #1;
        n_cmp++; if (out_ch(2) !== DW'('hA)) begin n_err++; $display("FAIL freeze_first: got %0h expected a", out_ch(2)); end
        next();
        #1;
        n_cmp++; if (out_ch(2) !== DW'('hB) || out_valid[2] !== 1'b1) begin n_err++; $display("FAIL freeze_second: got %0h/%b expected b/1", out_ch(2), out_valid[2]); end
        next();
        out_ready = '0;
        #1;
        n_cmp++; if (drained !== 1'b1) begin n_err++; $display("FAIL freeze_drained: got %b expected 1", drained); end
    endtask

    task automatic test_full_pop();
        ap_start = 1'b1;
        set_in(1, DW'('h11), 1'b1); #1; next();
        set_in(1, DW'('h22), 1'b1); #1; next();
        set_in(1, DW'('h33), 1'b1);
        out_ready[1] = 1'b1;
        #1;
        n_cmp++; if (in_ready[1] !== 1'b0) begin n_err++; $display("FAIL fullpop_ready: got %b expected 0", in_ready[1]); end
        n_cmp++; if (out_ch(1) !== DW'('h11)) begin n_err++; $display("FAIL fullpop_data: got %0h expected 11", out_ch(1)); end
        next();
        set_in(1, '0, 1'b0);
        out_ready[1] = 1'b0;
        #1;
        n_cmp++; if (out_ch(1) !== DW'('h22) || out_valid[1] !== 1'b1) begin n_err++; $display("FAIL fullpop_head: got %0h/%b expected 22/1", out_ch(1), out_valid[1]); end
        n_cmp++; if (in_ready[1] !== 1'b1) begin n_err++; $display("FAIL fullpop_occ1: got %b expected 1", in_ready[1]); end
        out_ready[1] = 1'b1;
        next();
        out_ready[1] = 1'b0;
        #1;
        n_cmp++; if (out_valid[1] !== 1'b0) begin n_err++; $display("FAIL fullpop_refused: got %b expected 0", out_valid[1]); end
    endtask

    task automatic test_flush();
        int sent;
        do_reset();
        ap_start = 1'b1;
        sent = 0;
        out_ready[3] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_in(3, DW'(i), sent < 7);
            #1;
            if (in_valid[3] && m_in_ready(3)) sent++;
            next();
        end
        set_in(3, DW'('h71), 1'b1);
        out_ready[3] = 1'b0;
        #1;
        n_cmp++; if (cnt_ch(3) !== CW'(7)) begin n_err++; $display("FAIL flush_precnt: got %0d expected 7", cnt_ch(3)); end
        next();
        set_in(3, DW'('h72), 1'b1); #1; next();
        set_in(3, DW'('h73), 1'b1);
        out_ready[3] = 1'b1;
        flush = 1'b1;
        #1;
        n_cmp++; if (in_ready[3] !== 1'b0) begin n_err++; $display("FAIL flush_ready: got %b expected 0", in_ready[3]); end
        next();
        flush = 1'b0;
        set_in(3, '0, 1'b0);
        out_ready[3] = 1'b0;
        #1;
        n_cmp++; if (out_valid[3] !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b expected 0", out_valid[3]); end
        n_cmp++; if (drained !== 1'b1) begin n_err++; $display("FAIL flush_drained: got %b expected 1", drained); end
        n_cmp++; if (cnt_ch(3) !== CW'(7)) begin n_err++; $display("FAIL flush_cnt: got %0d expected 7", cnt_ch(3)); end
    endtask

    task automatic test_cnt_wrap();
        int sent, pops;
        sent = 0; pops = 0;
        c4_ap_start = 1'b1; c4_out_ready = 1'b1;
        for (int i = 0; i < 25; i++) begin
            c4_in_data  = 8'(sent);
            c4_in_valid = 1'(sent < 17);
            #1;
            if (c4_out_valid[0]) begin
                n_cmp++;
                if (c4_out_data !== 8'(pops)) begin n_err++; $display("FAIL wrap_data: got %0h expected %0h", c4_out_data, 8'(pops)); end
                pops++;
            end
            if (c4_in_valid[0] && c4_in_ready[0]) sent++;
            @(posedge clk);
            #1;
        end
        c4_in_valid = '0; c4_out_ready = '0;
        n_cmp++; if (pops != 17) begin n_err++; $display("FAIL wrap_pops: got %0d expected 17", pops); end
        n_cmp++; if (c4_flit_cnt !== 4'd1) begin n_err++; $display("FAIL wrap_cnt: got %0d expected 1", c4_flit_cnt); end
        n_cmp++; if (c4_drained !== 1'b1) begin n_err++; $display("FAIL wrap_drained: got %b expected 1", c4_drained); end
    endtask

    task automatic test_async_reset();
        ap_start = 1'b1;
        for (int c = 0; c < NC; c++) set_in(c, DW'('h500 + c), 1'b1);
        #1; next();
        #1; next();
        n_cmp++; if (out_valid !== '1) begin n_err++; $display("FAIL areset_pre: got %b expected 1111", out_valid); end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (out_valid !== '0) begin n_err++; $display("FAIL areset_valid: got %b expected 0000", out_valid); end
        n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL areset_data: got %0h expected 0", out_data); end
        n_cmp++; if (in_ready !== '0) begin n_err++; $display("FAIL areset_ready: got %b expected 0000", in_ready); end
        n_cmp++; if (flit_cnt !== '0) begin n_err++; $display("FAIL areset_cnt: got %0h expected 0", flit_cnt); end
        n_cmp++; if (drained !== 1'b1) begin n_err++; $display("FAIL areset_drained: got %b expected 1", drained); end
        in_valid = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== '0) begin n_err++; $display("FAIL areset_after: got %b expected 0000", out_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stream();
        test_freeze();
        test_full_pop();
        test_flush();
        test_cnt_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
